// File: rtl/pl_bus_pkg.sv
// ---------------------------------------------------------------------------
// pl_bus_pkg
// Shared definitions for the SPI transmit-buffer arbiter:
//   - state_e    : arbiter FSM state encoding
//   - word_w()   : width of one buffer word (data byte plus end-of-frame bit)
//   - marker_bit(): bit index of the end-of-frame marker inside a buffer word
// ---------------------------------------------------------------------------
package pl_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_TXD  = 3'd2,
        S_WAIT = 3'd3,
        S_CMPT = 3'd4
    } state_e;

    // A buffer word carries the byte in its low bits and the marker on top.
    function automatic int word_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int marker_bit(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/pl_bus_tx_txd_arb_if.sv
// ---------------------------------------------------------------------------
// pl_bus_tx_txd_arb_if
// Handshake between the buffer arbiter and the SPI byte transmitter.
//   spit_idle  : transmitter has nothing in flight (driven by transmitter)
//   spit_dreq  : transmitter accepted the offered byte (driven by transmitter)
//   spit_valid : a byte is offered (driven by arbiter)
//   spit_data  : the offered byte (driven by arbiter)
//   spit_ch    : channel currently granted (driven by arbiter)
// Modports: master = arbiter side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface pl_bus_tx_txd_arb_if #(
    parameter int DATA_W = 8,
    parameter int CH_NUM = 4
);
    localparam int CH_W = $clog2(CH_NUM);

    logic              spit_idle;
    logic              spit_dreq;
    logic              spit_valid;
    logic [DATA_W-1:0] spit_data;
    logic [CH_W-1:0]   spit_ch;

    modport master (
        input  spit_idle,
        input  spit_dreq,
        output spit_valid,
        output spit_data,
        output spit_ch
    );

    modport slave (
        output spit_idle,
        output spit_dreq,
        input  spit_valid,
        input  spit_data,
        input  spit_ch
    );

endinterface

// File: rtl/pl_bus_rr_arb.sv
// ---------------------------------------------------------------------------
// pl_bus_rr_arb
// Combinational round-robin search: returns the first requesting channel at
// or after ptr, wrapping modulo CH_NUM.
//   req         : request vector, one bit per channel
//   ptr         : channel with highest priority this round (must be < CH_NUM)
//   grant       : index of the selected channel
//   grant_valid : at least one request was present
// ---------------------------------------------------------------------------
module pl_bus_rr_arb #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              grant_valid
);
    // Rotate the request vector so that bit 0 corresponds to channel ptr;
    // the lowest set bit of the rotated vector is then the winner's offset.
    logic [2*CH_NUM-1:0] req_dbl;
    logic [2*CH_NUM-1:0] req_shift;
    logic [CH_NUM-1:0]   req_rot;
    logic [CH_W-1:0]     offset;
    logic [CH_W:0]       sum;

    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> ptr;
    assign req_rot   = req_shift[CH_NUM-1:0];

    always_comb begin
        offset      = '0;
        grant_valid = 1'b0;
        // Walk downward so the lowest offset is the last one written.
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset      = CH_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (CH_W+1)'(CH_NUM)) begin
            grant = CH_W'(sum - (CH_W+1)'(CH_NUM));
        end else begin
            grant = CH_W'(sum);
        end
    end

endmodule

// File: rtl/pl_bus_tx_txd_arb.sv
// ---------------------------------------------------------------------------
// pl_bus_tx_txd_arb
// Arbitrates CH_NUM per-channel transmit buffers onto a single SPI byte
// transmitter. A granted channel is drained word by word until its buffer is
// empty, its head word carries the end-of-frame marker, or MAX_LEN words were
// sent (abort). Completion is reported per channel and held until the
// requester drops its txd_en level.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   txd_en     : per-channel transmit request level
//   txd_cmpt   : per-channel frame done, held until txd_en drops
//   txd_err    : per-channel MAX_LEN abort flag, valid with txd_cmpt
//   txb_req    : per-channel one-cycle buffer pop strobe
//   txb_data   : per-channel buffer head words, channel k at [k*W +: W]
//   txb_empty  : per-channel buffer empty
//   spit       : SPI transmitter handshake (master side)
//   txd_len    : data words sent in the current or last frame
// ---------------------------------------------------------------------------
module pl_bus_tx_txd_arb
    import pl_bus_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CH_NUM  = 4,
    parameter int LEN_W   = 12,
    // Must not exceed 2**LEN_W - 1 so txd_len can hold it without wrapping.
    parameter int MAX_LEN = 2048
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CH_NUM-1:0]             txd_en,
    output logic [CH_NUM-1:0]             txd_cmpt,
    output logic [CH_NUM-1:0]             txd_err,
    output logic [CH_NUM-1:0]             txb_req,
    input  logic [CH_NUM*(DATA_W+1)-1:0]  txb_data,
    input  logic [CH_NUM-1:0]             txb_empty,
    pl_bus_tx_txd_arb_if.master           spit,
    output logic [LEN_W-1:0]              txd_len
);
    localparam int WORD_W = word_w(DATA_W);
    localparam int MK     = marker_bit(DATA_W);
    localparam int CH_W   = $clog2(CH_NUM);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                abort_q, abort_d;
    logic [CH_NUM-1:0]   cmpt_q, cmpt_d;
    logic [CH_NUM-1:0]   err_q, err_d;
    logic [CH_NUM-1:0]   req_q, req_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;

    // Unpack the flat head-word bus into one word per channel.
    logic [WORD_W-1:0]   head_words [CH_NUM];

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_unpack
        assign head_words[gi] = txb_data[gi*WORD_W +: WORD_W];
    end

    logic [WORD_W-1:0]   head_g;
    logic                en_g;
    logic                empty_g;
    logic [CH_W-1:0]     next_ptr;

    assign head_g   = head_words[grant_q];
    assign en_g     = txd_en[grant_q];
    assign empty_g  = txb_empty[grant_q];
    assign next_ptr = (grant_q == CH_W'(CH_NUM - 1)) ? '0 : grant_q + CH_W'(1);

    // A channel still showing completion is not eligible until it drops txd_en.
    logic [CH_W-1:0]     arb_grant;
    logic                arb_valid;

    pl_bus_rr_arb #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_rr_arb (
        .req         (txd_en & ~cmpt_q),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        len_d    = len_q;
        abort_d  = abort_q;
        cmpt_d   = cmpt_q;
        err_d    = err_q;
        req_d    = '0;
        valid_d  = valid_q;
        data_d   = data_q;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    len_d   = '0;
                    abort_d = 1'b0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (!en_g) begin
                    // Requester withdrew: drop the frame silently, skip it next round.
                    valid_d  = 1'b0;
                    abort_d  = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else if (empty_g || head_g[MK]) begin
                    // End of frame; the marker word stays in the buffer.
                    state_d = S_WAIT;
                end else if (len_q == LEN_W'(MAX_LEN)) begin
                    abort_d = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    req_d[grant_q] = 1'b1;
                    valid_d        = 1'b1;
                    data_d         = head_g[DATA_W-1:0];
                    len_d          = len_q + LEN_W'(1);
                    state_d        = S_TXD;
                end
            end

            S_TXD: begin
                if (!en_g) begin
                    valid_d  = 1'b0;
                    abort_d  = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else if (spit.spit_dreq) begin
                    valid_d = 1'b0;
                    state_d = S_DATA;
                end
            end

            S_WAIT: begin
                if (!en_g) begin
                    valid_d  = 1'b0;
                    abort_d  = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else if (spit.spit_idle) begin
                    // Report only once the last byte has actually left the wire.
                    cmpt_d[grant_q] = 1'b1;
                    err_d[grant_q]  = abort_q;
                    state_d         = S_CMPT;
                end
            end

            S_CMPT: begin
                if (!en_g) begin
                    cmpt_d   = '0;
                    err_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            len_q    <= '0;
            abort_q  <= 1'b0;
            cmpt_q   <= '0;
            err_q    <= '0;
            req_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            abort_q  <= abort_d;
            cmpt_q   <= cmpt_d;
            err_q    <= err_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign txd_cmpt        = cmpt_q;
    assign txd_err         = err_q;
    assign txb_req         = req_q;
    assign txd_len         = len_q;
    assign spit.spit_valid = valid_q;
    assign spit.spit_data  = data_q;
    assign spit.spit_ch    = grant_q;

endmodule

// File: tb/tb_pl_bus_tx_txd_arb.sv
// ---------------------------------------------------------------------------
// tb_pl_bus_tx_txd_arb
// Self-checking bench for pl_bus_tx_txd_arb (DATA_W=8, CH_NUM=4, MAX_LEN=4).
// Buffers are modelled as queues that pop on txb_req; the SPI transmitter
// accepts a byte a configurable number of cycles after spit_valid appears.
// Expected frames are derived from the buffer contents at frame start.
// ---------------------------------------------------------------------------
module tb_pl_bus_tx_txd_arb;
    localparam int DW = 8;
    localparam int CH = 4;
    localparam int LW = 12;
    localparam int ML = 4;
    localparam int WW = DW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     txd_en;
    logic [CH-1:0]     txd_cmpt;
    logic [CH-1:0]     txd_err;
    logic [CH-1:0]     txb_req;
    logic [CH*WW-1:0]  txb_data;
    logic [CH-1:0]     txb_empty;
    logic [LW-1:0]     txd_len;

    pl_bus_tx_txd_arb_if #(.DATA_W(DW), .CH_NUM(CH)) bus ();

    pl_bus_tx_txd_arb #(
        .DATA_W  (DW),
        .CH_NUM  (CH),
        .LEN_W   (LW),
        .MAX_LEN (ML)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .txd_en    (txd_en),
        .txd_cmpt  (txd_cmpt),
        .txd_err   (txd_err),
        .txb_req   (txb_req),
        .txb_data  (txb_data),
        .txb_empty (txb_empty),
        .spit      (bus),
        .txd_len   (txd_len)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] bufq [CH][$];
    logic [WW-1:0] snap [CH][$];
    int            pops [CH];
    logic [DW-1:0] sent_data [$];
    int            sent_ch [$];
    int            stray;
    int            vcnt;
    int            idle_cnt;
    int            dreq_dly;
    int            idle_dly;
    int            rr_model;
    int            checks;
    int            errors;

    task automatic refresh();
        for (int k = 0; k < CH; k++) begin
            txb_empty[k] = (bufq[k].size() == 0);
            txb_data[k*WW +: WW] = (bufq[k].size() != 0) ? bufq[k][0] : '0;
        end
    endtask

    task automatic clear_log();
        sent_data.delete();
        sent_ch.delete();
        for (int k = 0; k < CH; k++) pops[k] = 0;
        stray = 0;
    endtask

    task automatic clear_bufs();
        for (int k = 0; k < CH; k++) bufq[k].delete();
        refresh();
    endtask

    // One clock: drive transmitter responses, log accepted bytes, then step
    // past the edge and apply buffer pops.
    task automatic cycle();
        logic [CH-1:0] req_s;
        if (bus.spit_valid) begin
            vcnt++;
            bus.spit_dreq = (vcnt > dreq_dly);
            idle_cnt = 0;
        end else begin
            vcnt = 0;
            bus.spit_dreq = 1'b0;
            idle_cnt++;
        end
        bus.spit_idle = (idle_cnt > idle_dly);
        req_s = txb_req;
        if (req_s != '0 && req_s != (4'b0001 << bus.spit_ch)) stray++;
        if (rst && bus.spit_valid && bus.spit_dreq) begin
            sent_data.push_back(bus.spit_data);
            sent_ch.push_back(int'(bus.spit_ch));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) begin
            if (req_s[k]) begin
                pops[k]++;
                if (bufq[k].size() != 0) void'(bufq[k].pop_front());
            end
        end
        refresh();
    endtask

    task automatic wait_cmpt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (txd_cmpt != '0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.spit_valid) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cycle();
        cycle();
        checks++; if (txd_cmpt !== 4'b0) begin errors++; $display("FAIL reset_cmpt got %h want 0", txd_cmpt); end
        checks++; if (txd_err !== 4'b0) begin errors++; $display("FAIL reset_err got %h want 0", txd_err); end
        checks++; if (txb_req !== 4'b0) begin errors++; $display("FAIL reset_req got %h want 0", txb_req); end
        checks++; if (bus.spit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.spit_valid); end
        checks++; if (bus.spit_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.spit_data); end
        checks++; if (bus.spit_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d want 0", bus.spit_ch); end
        checks++; if (txd_len !== 12'd0) begin errors++; $display("FAIL reset_len got %0d want 0", txd_len); end
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        bit ok;
        clear_bufs();
        bufq[0].push_back(9'h011);
        bufq[0].push_back(9'h022);
        bufq[0].push_back(9'h1a5);
        refresh();
        clear_log();
        dreq_dly = 3;
        idle_dly = 2;
        txd_en = 4'b0001;
        cycle();
        checks++; if (bus.spit_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_grant valid got %b want 0", bus.spit_valid); end
        cycle();
        checks++; if (bus.spit_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_valid got %b want 1", bus.spit_valid); end
        checks++; if (bus.spit_data !== 8'h11) begin errors++; $display("FAIL basic_first_data got %h want 11", bus.spit_data); end
        wait_cmpt(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no txd_cmpt want txd_cmpt"); end
        checks++; if (txd_cmpt !== 4'b0001) begin errors++; $display("FAIL basic_cmpt got %b want 0001", txd_cmpt); end
        checks++; if (txd_err !== 4'b0000) begin errors++; $display("FAIL basic_err got %b want 0000", txd_err); end
        checks++; if (txd_len !== 12'd2) begin errors++; $display("FAIL basic_len got %0d want 2", txd_len); end
        checks++; if (pops[0] !== 2) begin errors++; $display("FAIL basic_pops got %0d want 2", pops[0]); end
        checks++; if (sent_data.size() !== 2) begin errors++; $display("FAIL basic_nbytes got %0d want 2", sent_data.size()); end
        else begin
            checks++; if (sent_data[0] !== 8'h11 || sent_data[1] !== 8'h22) begin errors++; $display("FAIL basic_bytes got %h %h want 11 22", sent_data[0], sent_data[1]); end
            checks++; if (sent_ch[0] !== 0 || sent_ch[1] !== 0) begin errors++; $display("FAIL basic_ch got %0d %0d want 0 0", sent_ch[0], sent_ch[1]); end
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL basic_stray_req got %0d want 0", stray); end
        clear_bufs();
        clear_log();
        txd_en = 4'b0000;
        cycle();
        checks++; if (txd_cmpt !== 4'b0000) begin errors++; $display("FAIL basic_cmpt_clear got %b want 0000", txd_cmpt); end
    endtask

    task automatic test_rr();
        bit ok;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        clear_bufs();
        bufq[1].push_back(9'h0a1);
        bufq[1].push_back(9'h100);
        bufq[3].push_back(9'h0b3);
        bufq[3].push_back(9'h0c3);
        bufq[3].push_back(9'h100);
        refresh();
        clear_log();
        txd_en = 4'b1010;
        wait_cmpt(ok);
        checks++; if (txd_cmpt !== 4'b0010) begin errors++; $display("FAIL rr_first got %b want 0010 ok=%0d", txd_cmpt, ok); end
        checks++; if (sent_data.size() !== 1 || sent_data[0] !== 8'ha1) begin errors++; $display("FAIL rr_first_bytes got n=%0d want 1 byte a1", sent_data.size()); end
        bufq[1].delete();
        refresh();
        clear_log();
        txd_en[1] = 1'b0;
        cycle();
        wait_cmpt(ok);
        checks++; if (txd_cmpt !== 4'b1000) begin errors++; $display("FAIL rr_second got %b want 1000 ok=%0d", txd_cmpt, ok); end
        checks++; if (txd_len !== 12'd2) begin errors++; $display("FAIL rr_second_len got %0d want 2", txd_len); end
        checks++; if (sent_data.size() !== 2 || sent_ch[0] !== 3) begin errors++; $display("FAIL rr_second_bytes got n=%0d want 2 on ch3", sent_data.size()); end
        clear_bufs();
        clear_log();
        txd_en = 4'b0000;
        cycle();
    endtask

    task automatic test_empty();
        bit ok;
        clear_bufs();
        clear_log();
        txd_en = 4'b0100;
        wait_cmpt(ok);
        checks++; if (txd_cmpt !== 4'b0100) begin errors++; $display("FAIL empty_cmpt got %b want 0100 ok=%0d", txd_cmpt, ok); end
        checks++; if (txd_len !== 12'd0) begin errors++; $display("FAIL empty_len got %0d want 0", txd_len); end
        checks++; if (pops[2] !== 0 || stray !== 0) begin errors++; $display("FAIL empty_req got pops=%0d stray=%0d want 0 0", pops[2], stray); end
        checks++; if (txd_err !== 4'b0000) begin errors++; $display("FAIL empty_err got %b want 0000", txd_err); end
        txd_en = 4'b0000;
        cycle();
    endtask

    task automatic test_maxlen();
        bit ok;
        clear_bufs();
        for (int i = 1; i <= 6; i++) bufq[0].push_back(9'(i));
        bufq[0].push_back(9'h100);
        refresh();
        clear_log();
        dreq_dly = 1;
        txd_en = 4'b0001;
        wait_cmpt(ok);
        checks++; if (txd_cmpt !== 4'b0001) begin errors++; $display("FAIL maxlen_cmpt got %b want 0001 ok=%0d", txd_cmpt, ok); end
        checks++; if (txd_err !== 4'b0001) begin errors++; $display("FAIL maxlen_err got %b want 0001", txd_err); end
        checks++; if (txd_len !== 12'd4) begin errors++; $display("FAIL maxlen_len got %0d want 4", txd_len); end
        checks++; if (sent_data.size() !== 4) begin errors++; $display("FAIL maxlen_nbytes got %0d want 4", sent_data.size()); end
        else begin
            checks++; if (sent_data[3] !== 8'h04) begin errors++; $display("FAIL maxlen_last got %h want 04", sent_data[3]); end
        end
        clear_bufs();
        clear_log();
        txd_en = 4'b0000;
        cycle();
        checks++; if (txd_err !== 4'b0000) begin errors++; $display("FAIL maxlen_err_clear got %b want 0000", txd_err); end
    endtask

    task automatic test_drop_txd();
        bit ok;
        clear_bufs();
        bufq[1].push_back(9'h031);
        bufq[1].push_back(9'h032);
        bufq[1].push_back(9'h100);
        refresh();
        clear_log();
        dreq_dly = 50;
        txd_en = 4'b0010;
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_no_valid got valid=0 want 1"); end
        txd_en[1] = 1'b0;
        cycle();
        checks++; if (bus.spit_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b want 0", bus.spit_valid); end
        cycle();
        cycle();
        checks++; if (txd_cmpt !== 4'b0000) begin errors++; $display("FAIL drop_cmpt got %b want 0000", txd_cmpt); end
        checks++; if (sent_data.size() !== 0) begin errors++; $display("FAIL drop_bytes got %0d want 0", sent_data.size()); end
        // Pointer must have moved past channel 1, so channel 2 wins over 1.
        clear_bufs();
        bufq[1].push_back(9'h055);
        bufq[1].push_back(9'h100);
        bufq[2].push_back(9'h066);
        bufq[2].push_back(9'h100);
        refresh();
        clear_log();
        dreq_dly = 1;
        txd_en = 4'b0110;
        wait_cmpt(ok);
        checks++; if (txd_cmpt !== 4'b0100) begin errors++; $display("FAIL drop_rr got %b want 0100 ok=%0d", txd_cmpt, ok); end
        checks++; if (sent_data.size() !== 1 || sent_data[0] !== 8'h66) begin errors++; $display("FAIL drop_rr_bytes got n=%0d want 1 byte 66", sent_data.size()); end
        clear_bufs();
        clear_log();
        txd_en = 4'b0000;
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_bufs();
        bufq[3].push_back(9'h041);
        bufq[3].push_back(9'h042);
        bufq[3].push_back(9'h100);
        refresh();
        clear_log();
        dreq_dly = 50;
        txd_en = 4'b1000;
        wait_valid(ok);
        rst = 1'b0;
        cycle();
        checks++; if (bus.spit_valid !== 1'b0 || bus.spit_data !== 8'h00) begin errors++; $display("FAIL rstmid_spi got valid=%b data=%h want 0 00", bus.spit_valid, bus.spit_data); end
        checks++; if (bus.spit_ch !== 2'd0 || txd_len !== 12'd0) begin errors++; $display("FAIL rstmid_ch_len got ch=%0d len=%0d want 0 0", bus.spit_ch, txd_len); end
        checks++; if (txb_req !== 4'b0 || txd_cmpt !== 4'b0 || txd_err !== 4'b0) begin errors++; $display("FAIL rstmid_flags got req=%b cmpt=%b err=%b want 0", txb_req, txd_cmpt, txd_err); end
        txd_en = 4'b0000;
        rst = 1'b1;
        clear_bufs();
        cycle();
        // Restart: pointer is back at 0, so channel 0 beats channel 3.
        bufq[0].push_back(9'h077);
        bufq[0].push_back(9'h100);
        bufq[3].push_back(9'h088);
        bufq[3].push_back(9'h100);
        refresh();
        clear_log();
        dreq_dly = 2;
        txd_en = 4'b1001;
        wait_cmpt(ok);
        checks++; if (txd_cmpt !== 4'b0001) begin errors++; $display("FAIL rstmid_restart got %b want 0001 ok=%0d", txd_cmpt, ok); end
        checks++; if (sent_data.size() !== 1 || sent_data[0] !== 8'h77) begin errors++; $display("FAIL rstmid_restart_bytes got n=%0d want 1 byte 77", sent_data.size()); end
        clear_bufs();
        clear_log();
        txd_en = 4'b0000;
        cycle();
        cycle();
    endtask

    task automatic test_random();
        bit        ok;
        int        n_exp;
        bit        err_exp;
        int        exp_ch;
        int        c;
        int        nw;
        logic [CH-1:0] pending;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rr_model = 0;
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < CH; k++) begin
                bufq[k].delete();
                if ($urandom_range(0, 3) != 0) begin
                    nw = $urandom_range(0, 6);
                    for (int w = 0; w < nw; w++) bufq[k].push_back({1'b0, 8'($urandom)});
                    if ($urandom_range(0, 4) != 0) bufq[k].push_back({1'b1, 8'($urandom)});
                end
                snap[k] = bufq[k];
            end
            refresh();
            clear_log();
            dreq_dly = $urandom_range(0, 3);
            idle_dly = $urandom_range(0, 3);
            pending = 4'($urandom_range(1, 15));
            txd_en = pending;
            while (pending != '0) begin
                exp_ch = -1;
                for (int j = 0; j < CH; j++) begin
                    c = (rr_model + j) % CH;
                    if (exp_ch < 0 && pending[c]) exp_ch = c;
                end
                wait_cmpt(ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL rand_timeout it=%0d got no txd_cmpt want ch%0d", it, exp_ch);
                    txd_en = '0;
                    rst = 1'b0;
                    cycle();
                    rst = 1'b1;
                    cycle();
                    rr_model = 0;
                    pending = '0;
                end else begin
                    // Frame = data words up to marker/empty, at most ML of them.
                    n_exp = 0;
                    while (n_exp < snap[exp_ch].size() && n_exp < ML && !snap[exp_ch][n_exp][DW]) n_exp++;
                    err_exp = (n_exp == ML) && (n_exp < snap[exp_ch].size()) && !snap[exp_ch][n_exp][DW];
                    if (txd_cmpt !== (4'b0001 << exp_ch)) begin errors++; $display("FAIL rand_grant it=%0d got %b want ch%0d", it, txd_cmpt, exp_ch); end
                    checks++; if (txd_len !== LW'(n_exp)) begin errors++; $display("FAIL rand_len it=%0d got %0d want %0d", it, txd_len, n_exp); end
                    checks++; if (txd_err !== (err_exp ? (4'b0001 << exp_ch) : 4'b0000)) begin errors++; $display("FAIL rand_err it=%0d got %b want %0d on ch%0d", it, txd_err, err_exp, exp_ch); end
                    checks++; if (pops[exp_ch] !== n_exp || stray !== 0) begin errors++; $display("FAIL rand_pops it=%0d got %0d stray=%0d want %0d 0", it, pops[exp_ch], stray, n_exp); end
                    checks++;
                    if (sent_data.size() !== n_exp) begin
                        errors++;
                        $display("FAIL rand_nbytes it=%0d got %0d want %0d", it, sent_data.size(), n_exp);
                    end else begin
                        for (int i = 0; i < n_exp; i++) begin
                            checks++;
                            if (sent_data[i] !== snap[exp_ch][i][DW-1:0] || sent_ch[i] !== exp_ch) begin
                                errors++;
                                $display("FAIL rand_byte it=%0d idx=%0d got %h/ch%0d want %h/ch%0d", it, i, sent_data[i], sent_ch[i], snap[exp_ch][i][DW-1:0], exp_ch);
                            end
                        end
                    end
                    bufq[exp_ch].delete();
                    refresh();
                    clear_log();
                    txd_en[exp_ch] = 1'b0;
                    pending[exp_ch] = 1'b0;
                    rr_model = (exp_ch + 1) % CH;
                    cycle();
                end
            end
            cycle();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        txd_en        = '0;
        txb_data      = '0;
        txb_empty     = '1;
        bus.spit_idle = 1'b1;
        bus.spit_dreq = 1'b0;
        vcnt          = 0;
        idle_cnt      = 0;
        dreq_dly      = 3;
        idle_dly      = 2;
        rr_model      = 0;
        clear_bufs();
        clear_log();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_rr();
        test_empty();
        test_maxlen();
        test_drop_txd();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
